vernam_key_mailbox: RTL and testbench

Controller between the key-generator PicoBlaze (pb2) and the cipher PicoBlaze (pb1). It replaces the ad-hoc interrupt flop, output flops and input mux with one block. Key bytes from pb2 are buffered in a small FIFO, and pb1 is interrupted for each delivered byte. pb2 is throttled by a refill interrupt and by status flags readable by both processors.

---
 rtl/vernam_pkg.sv | 31 +++
 rtl/vernam_key_fifo.sv | 62 ++++++
 rtl/vernam_key_mailbox.sv | 144 ++++++++++++++
 tb/tb_vernam_key_mailbox.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vernam_pkg.sv
// Shared constants for the pb1/pb2 key mailbox: port addresses, status byte
// layout and control register bit positions.
package vernam_pkg;

  // Port addresses (exact 8-bit matches)
  localparam logic [7:0] KEY_DATA = 8'h80;  // pb1 read: FIFO head, pops on strobe
  localparam logic [7:0] STATUS   = 8'h81;  // pb1 read: status byte
  localparam logic [7:0] CTRL     = 8'h82;  // pb1 write: control register
  localparam logic [7:0] PB2_KEY  = 8'h01;  // pb2 write: push, pb2 read: status

  // Status byte bit indices
  localparam int unsigned ST_FULL  = 7;
  localparam int unsigned ST_EMPTY = 6;
  localparam int unsigned ST_OVF   = 5;
  localparam int unsigned ST_UNF   = 4;
  localparam int unsigned ST_CNT_W = 4;

  // Control register bit indices
  localparam int unsigned CTRL_PB1_EN = 0;
  localparam int unsigned CTRL_PB2_EN = 1;
  localparam int unsigned CTRL_CLR    = 7;  // write-one-clear of sticky flags, not stored

  typedef struct packed {
    logic                full;
    logic                empty;
    logic                ovf;
    logic                unf;
    logic [ST_CNT_W-1:0] count;
  } status_t;

endpackage

// File: rtl/vernam_key_fifo.sv
// DEPTH x 8 key byte FIFO with extra-bit pointers to tell full from empty.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   push, din         write request and data (dropped when full unless popping)
//   pop, dout         read request; dout is the current head (0x00 when empty)
//   count/full/empty  occupancy, valid in the cycle they are read
//   ovf_pulse         push rejected this cycle
//   unf_pulse         pop on empty this cycle
module vernam_key_fifo #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          ovf_pulse,
  output logic          unf_pulse
);

  logic [7:0]    r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign count = r_wr_ptr - r_rd_ptr;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push_ok = push & (~full | pop);
  assign w_pop_ok  = pop & ~empty;
  assign ovf_pulse = push & full & ~pop;
  assign unf_pulse = pop & empty;

  assign dout = empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + CW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + CW'(1);
    end
  end

  // Storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/vernam_key_mailbox.sv
// Key mailbox between generator PicoBlaze (pb2) and cipher PicoBlaze (pb1).
// pb2 pushes key bytes into a FIFO; pb1 pops them and is interrupted per
// delivered byte; pb2 gets a refill interrupt when the FIFO runs low.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   pb1_port_id/out_port/strobes    cipher I/O bus; pb1_in_port combinational
//   pb1_interrupt/_ack              key-available interrupt (registered)
//   pb2_port_id/out_port/strobes    generator I/O bus; pb2_in_port combinational
//   pb2_interrupt/_ack              refill interrupt (registered)
module vernam_key_mailbox #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned LOW_WATER = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pb1_port_id,
  input  logic [7:0] pb1_out_port,
  input  logic       pb1_write_strobe,
  input  logic       pb1_read_strobe,
  output logic [7:0] pb1_in_port,
  output logic       pb1_interrupt,
  input  logic       pb1_interrupt_ack,
  input  logic [7:0] pb2_port_id,
  input  logic [7:0] pb2_out_port,
  input  logic       pb2_write_strobe,
  input  logic       pb2_read_strobe,
  output logic [7:0] pb2_in_port,
  output logic       pb2_interrupt,
  input  logic       pb2_interrupt_ack
);

  import vernam_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          r_pb1_irq_en;
  logic          r_pb2_irq_en;
  logic          r_ovf;
  logic          r_unf;
  logic          r_pb1_irq;
  logic          r_pb2_irq;

  logic          w_push;
  logic          w_pop;
  logic          w_ctrl_wr;
  logic          w_clr;
  logic [7:0]    w_dout;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_ovf;
  logic          w_unf;
  logic          w_push_acc;
  logic          w_pop_acc;
  logic [CW-1:0] w_post_count;
  logic          w_pb1_set;
  logic          w_pb2_set;
  status_t       w_status;
  logic          w_unused;

  // Bus decode
  assign w_push    = pb2_write_strobe & (pb2_port_id == PB2_KEY);
  assign w_pop     = pb1_read_strobe  & (pb1_port_id == KEY_DATA);
  assign w_ctrl_wr = pb1_write_strobe & (pb1_port_id == CTRL);
  assign w_clr     = w_ctrl_wr & pb1_out_port[CTRL_CLR];

  vernam_key_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .pop       (w_pop),
    .din       (pb2_out_port),
    .dout      (w_dout),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty),
    .ovf_pulse (w_ovf),
    .unf_pulse (w_unf)
  );

  assign w_push_acc = w_push & ~w_ovf;
  assign w_pop_acc  = w_pop & ~w_unf;

  // Occupancy after this cycle's accepted pop (and any accepted push)
  assign w_post_count = w_count - CW'(1) + CW'(w_push_acc);

  assign w_pb1_set = w_push_acc & r_pb1_irq_en;
  assign w_pb2_set = w_pop_acc & r_pb2_irq_en & (w_post_count <= CW'(LOW_WATER));

  assign w_status = '{full:  w_full,
                      empty: w_empty,
                      ovf:   r_ovf,
                      unf:   r_unf,
                      count: ST_CNT_W'(w_count)};

  // Read data muxes; kcpsm3 samples in_port late in the strobe cycle
  always_comb begin
    pb1_in_port = 8'h00;
    pb2_in_port = 8'h00;
    case (pb1_port_id)
      KEY_DATA: pb1_in_port = w_dout;
      STATUS:   pb1_in_port = w_status;
      default:  pb1_in_port = 8'h00;
    endcase
    if (pb2_port_id == PB2_KEY) pb2_in_port = w_status;
  end

  // Control register and sticky flags; a new event beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pb1_irq_en <= 1'b1;
      r_pb2_irq_en <= 1'b1;
      r_ovf        <= 1'b0;
      r_unf        <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_pb1_irq_en <= pb1_out_port[CTRL_PB1_EN];
        r_pb2_irq_en <= pb1_out_port[CTRL_PB2_EN];
      end
      r_ovf <= w_ovf | (r_ovf & ~w_clr);
      r_unf <= w_unf | (r_unf & ~w_clr);
    end
  end

  // Interrupt flops; set has priority over ack
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pb1_irq <= 1'b0;
      r_pb2_irq <= 1'b0;
    end else begin
      if (w_pb1_set)              r_pb1_irq <= 1'b1;
      else if (pb1_interrupt_ack) r_pb1_irq <= 1'b0;
      if (w_pb2_set)              r_pb2_irq <= 1'b1;
      else if (pb2_interrupt_ack) r_pb2_irq <= 1'b0;
    end
  end

  assign pb1_interrupt = r_pb1_irq;
  assign pb2_interrupt = r_pb2_irq;

  // pb2 reads have no side effects; control bits 6:2 are reserved
  assign w_unused = &{1'b0, pb2_read_strobe, pb1_out_port[6:2]};

endmodule

// File: tb/tb_vernam_key_mailbox.sv
module tb_vernam_key_mailbox;

  logic       clk;
  logic       reset;
  logic [7:0] pb1_port_id;
  logic [7:0] pb1_out_port;
  logic       pb1_write_strobe;
  logic       pb1_read_strobe;
  logic [7:0] pb1_in_port;
  logic       pb1_interrupt;
  logic       pb1_interrupt_ack;
  logic [7:0] pb2_port_id;
  logic [7:0] pb2_out_port;
  logic       pb2_write_strobe;
  logic       pb2_read_strobe;
  logic [7:0] pb2_in_port;
  logic       pb2_interrupt;
  logic       pb2_interrupt_ack;

  int n_checks = 0;
  int n_fail   = 0;

  vernam_key_mailbox #(.DEPTH(4), .LOW_WATER(1)) dut (
    .clk               (clk),
    .reset             (reset),
    .pb1_port_id       (pb1_port_id),
    .pb1_out_port      (pb1_out_port),
    .pb1_write_strobe  (pb1_write_strobe),
    .pb1_read_strobe   (pb1_read_strobe),
    .pb1_in_port       (pb1_in_port),
    .pb1_interrupt     (pb1_interrupt),
    .pb1_interrupt_ack (pb1_interrupt_ack),
    .pb2_port_id       (pb2_port_id),
    .pb2_out_port      (pb2_out_port),
    .pb2_write_strobe  (pb2_write_strobe),
    .pb2_read_strobe   (pb2_read_strobe),
    .pb2_in_port       (pb2_in_port),
    .pb2_interrupt     (pb2_interrupt),
    .pb2_interrupt_ack (pb2_interrupt_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helpers: all start and end 1 time unit after a rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pb2_push(input logic [7:0] d);
    pb2_port_id = 8'h01; pb2_out_port = d; pb2_write_strobe = 1'b1;
    step();
    pb2_write_strobe = 1'b0; pb2_port_id = 8'h00; pb2_out_port = 8'h00;
  endtask

  task automatic pb1_rd(input logic [7:0] addr, output logic [7:0] data);
    pb1_port_id = addr; pb1_read_strobe = 1'b1;
    #1 data = pb1_in_port;
    step();
    pb1_read_strobe = 1'b0; pb1_port_id = 8'h00;
  endtask

  task automatic pb1_wr(input logic [7:0] addr, input logic [7:0] d);
    pb1_port_id = addr; pb1_out_port = d; pb1_write_strobe = 1'b1;
    step();
    pb1_write_strobe = 1'b0; pb1_port_id = 8'h00; pb1_out_port = 8'h00;
  endtask

  task automatic ack_both();
    pb1_interrupt_ack = 1'b1; pb2_interrupt_ack = 1'b1;
    step();
    pb1_interrupt_ack = 1'b0; pb2_interrupt_ack = 1'b0;
  endtask

  // Push on pb2 and pop on pb1 in the same cycle; returns the popped byte
  task automatic push_pop(input logic [7:0] d, output logic [7:0] data);
    pb2_port_id = 8'h01; pb2_out_port = d; pb2_write_strobe = 1'b1;
    pb1_port_id = 8'h80; pb1_read_strobe = 1'b1;
    #1 data = pb1_in_port;
    step();
    pb2_write_strobe = 1'b0; pb2_port_id = 8'h00; pb2_out_port = 8'h00;
    pb1_read_strobe = 1'b0; pb1_port_id = 8'h00;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    n_checks++;
    if (pb1_interrupt !== 1'b0 || pb2_interrupt !== 1'b0) begin
      n_fail++; $display("FAIL reset_irq got=%b%b exp=00", pb1_interrupt, pb2_interrupt);
    end
    n_checks++;
    if (pb1_in_port !== 8'h00 || pb2_in_port !== 8'h00) begin
      n_fail++; $display("FAIL reset_in_port got=%02h/%02h exp=00/00", pb1_in_port, pb2_in_port);
    end
    pb1_rd(8'h81, d);
    n_checks++;
    if (d !== 8'h40) begin n_fail++; $display("FAIL reset_status got=%02h exp=40", d); end
    pb2_port_id = 8'h01; #1;
    n_checks++;
    if (pb2_in_port !== 8'h40) begin n_fail++; $display("FAIL reset_pb2_status got=%02h exp=40", pb2_in_port); end
    pb2_port_id = 8'h02; #1;
    n_checks++;
    if (pb2_in_port !== 8'h00) begin n_fail++; $display("FAIL pb2_unmapped got=%02h exp=00", pb2_in_port); end
    pb2_port_id = 8'h00;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] d;
    pb2_push(8'hA5);
    n_checks++;
    if (pb1_interrupt !== 1'b1) begin n_fail++; $display("FAIL basic_irq1 got=%b exp=1", pb1_interrupt); end
    ack_both();
    n_checks++;
    if (pb1_interrupt !== 1'b0) begin n_fail++; $display("FAIL basic_ack got=%b exp=0", pb1_interrupt); end
    pb2_push(8'h3C);
    pb1_rd(8'h81, d);
    n_checks++;
    if (d !== 8'h02) begin n_fail++; $display("FAIL basic_status got=%02h exp=02", d); end
    pb1_rd(8'h55, d);
    n_checks++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL pb1_unmapped got=%02h exp=00", d); end
    pb1_rd(8'h80, d);
    n_checks++;
    if (d !== 8'hA5) begin n_fail++; $display("FAIL basic_pop1 got=%02h exp=a5", d); end
    // post-pop count 1 <= LOW_WATER 1
    n_checks++;
    if (pb2_interrupt !== 1'b1) begin n_fail++; $display("FAIL basic_pb2_irq1 got=%b exp=1", pb2_interrupt); end
    ack_both();
    n_checks++;
    if (pb2_interrupt !== 1'b0) begin n_fail++; $display("FAIL basic_pb2_ack got=%b exp=0", pb2_interrupt); end
    pb1_rd(8'h80, d);
    n_checks++;
    if (d !== 8'h3C) begin n_fail++; $display("FAIL basic_pop2 got=%02h exp=3c", d); end
    n_checks++;
    if (pb2_interrupt !== 1'b1) begin n_fail++; $display("FAIL basic_pb2_irq2 got=%b exp=1", pb2_interrupt); end
    pb1_rd(8'h81, d);
    n_checks++;
    if (d !== 8'h40) begin n_fail++; $display("FAIL basic_empty got=%02h exp=40", d); end
    ack_both();
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    for (int i = 1; i <= 5; i++) pb2_push(8'(i));
    pb1_rd(8'h81, d);
    n_checks++;
    if (d !== 8'hA4) begin n_fail++; $display("FAIL ovf_status got=%02h exp=a4", d); end
    for (int i = 1; i <= 4; i++) begin
      pb1_rd(8'h80, d);
      n_checks++;
      if (d !== 8'(i)) begin n_fail++; $display("FAIL ovf_pop%0d got=%02h exp=%02h", i, d, 8'(i)); end
    end
    pb1_rd(8'h81, d);
    n_checks++;
    if (d !== 8'h60) begin n_fail++; $display("FAIL ovf_drained got=%02h exp=60", d); end
    pb1_wr(8'h82, 8'h83);
    pb1_rd(8'h81, d);
    n_checks++;
    if (d !== 8'h40) begin n_fail++; $display("FAIL ovf_clear got=%02h exp=40", d); end
    ack_both();
  endtask

  task automatic test_underflow();
    logic [7:0] d;
    pb1_rd(8'h80, d);
    n_checks++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL unf_data got=%02h exp=00", d); end
    pb1_rd(8'h81, d);
    n_checks++;
    if (d !== 8'h50) begin n_fail++; $display("FAIL unf_status got=%02h exp=50", d); end
    pb1_wr(8'h82, 8'h83);
    // Full FIFO, simultaneous push and pop
    for (int i = 0; i < 4; i++) pb2_push(8'h10 + 8'(i));
    push_pop(8'h14, d);
    n_checks++;
    if (d !== 8'h10) begin n_fail++; $display("FAIL full_pp_data got=%02h exp=10", d); end
    pb1_rd(8'h81, d);
    n_checks++;
    if (d !== 8'h84) begin n_fail++; $display("FAIL full_pp_status got=%02h exp=84", d); end
    for (int i = 1; i <= 4; i++) begin
      pb1_rd(8'h80, d);
      n_checks++;
      if (d !== 8'h10 + 8'(i)) begin n_fail++; $display("FAIL full_pp_order%0d got=%02h exp=%02h", i, d, 8'h10 + 8'(i)); end
    end
    // Empty FIFO, simultaneous push and pop
    push_pop(8'h15, d);
    n_checks++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL empty_pp_data got=%02h exp=00", d); end
    pb1_rd(8'h81, d);
    n_checks++;
    if (d !== 8'h11) begin n_fail++; $display("FAIL empty_pp_status got=%02h exp=11", d); end
    pb1_rd(8'h80, d);
    n_checks++;
    if (d !== 8'h15) begin n_fail++; $display("FAIL empty_pp_pop got=%02h exp=15", d); end
    pb1_wr(8'h82, 8'h83);
    pb1_rd(8'h81, d);
    n_checks++;
    if (d !== 8'h40) begin n_fail++; $display("FAIL unf_clear got=%02h exp=40", d); end
    ack_both();
  endtask

  task automatic test_irq();
    logic [7:0] d;
    pb2_push(8'h77);
    // push and ack in the same cycle: set wins
    pb1_interrupt_ack = 1'b1;
    pb2_push(8'h78);
    pb1_interrupt_ack = 1'b0;
    n_checks++;
    if (pb1_interrupt !== 1'b1) begin n_fail++; $display("FAIL irq_set_wins got=%b exp=1", pb1_interrupt); end
    pb1_wr(8'h82, 8'h02);
    n_checks++;
    if (pb1_interrupt !== 1'b1) begin n_fail++; $display("FAIL irq_en_keeps_pending got=%b exp=1", pb1_interrupt); end
    ack_both();
    pb2_push(8'h79);
    n_checks++;
    if (pb1_interrupt !== 1'b0) begin n_fail++; $display("FAIL irq_disabled got=%b exp=0", pb1_interrupt); end
    pb1_rd(8'h81, d);
    n_checks++;
    if (d !== 8'h03) begin n_fail++; $display("FAIL irq_count got=%02h exp=03", d); end
    // read strobe on an unmapped address must not pop
    pb1_rd(8'h90, d);
    pb1_rd(8'h81, d);
    n_checks++;
    if (d !== 8'h03) begin n_fail++; $display("FAIL unmapped_no_pop got=%02h exp=03", d); end
    pb1_wr(8'h82, 8'h03);
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 3; i++) pb2_push(8'hC0 + 8'(i));
    n_checks++;
    if (pb1_interrupt !== 1'b1) begin n_fail++; $display("FAIL mid_irq_pending got=%b exp=1", pb1_interrupt); end
    reset = 1'b1; step(); reset = 1'b0;
    pb1_port_id = 8'h81; #1 d = pb1_in_port;
    pb1_port_id = 8'h00;
    n_checks++;
    if (d !== 8'h40) begin n_fail++; $display("FAIL mid_reset_status got=%02h exp=40", d); end
    n_checks++;
    if (pb1_interrupt !== 1'b0 || pb2_interrupt !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_irq got=%b%b exp=00", pb1_interrupt, pb2_interrupt);
    end
    step();
  endtask

  initial begin
    reset = 1'b1;
    pb1_port_id = 8'h00; pb1_out_port = 8'h00;
    pb1_write_strobe = 1'b0; pb1_read_strobe = 1'b0; pb1_interrupt_ack = 1'b0;
    pb2_port_id = 8'h00; pb2_out_port = 8'h00;
    pb2_write_strobe = 1'b0; pb2_read_strobe = 1'b0; pb2_interrupt_ack = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_underflow();
    test_irq();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
